segre_wb_arbiter: RTL and testbench
===================================

// Module: segre_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between the EX, MEM and RVM pipeline completions.
//  Each source owns a small skid FIFO; a round-robin arbiter drains one entry per cycle to the RF.
//  Per-source full flags feed issue/decode so it stalls the matching pipeline.
//  Sits between the pipeline wrapper outputs (rf_wdata_t fields) and the register file.
// PARAMETERS
//  DATA_WIDTH  32  width of write data
//  REG_SIZE    5   width of register address
//  HF_PTR      4   width of history-file instruction id
//  FIFO_DEPTH  2   entries per source FIFO; must be >= 1 and a power of two
// PORTS
//  clk_i          in   1                     clock
//  rsn_i          in   1                     reset; synchronous, active-low
//  src_we_i       in   3                     completion valid per source [WB_EX, WB_MEM, WB_RVM]
//  src_waddr_i    in   3 x REG_SIZE          destination register per source
//  src_data_i     in   3 x DATA_WIDTH        write data per source
//  src_id_i       in   3 x HF_PTR            instruction id per source
//  src_full_o     out  3                     FIFO full per source; issue stalls that pipeline
//  rf_we_o        out  1                     RF write enable
//  rf_waddr_o     out  REG_SIZE              RF write address
//  rf_data_o      out  DATA_WIDTH            RF write data
//  rf_instr_id_o  out  HF_PTR                id of the retiring write, to the history file
// BEHAVIOUR
//  - Reset (rsn_i=0 at posedge): FIFOs emptied, counts 0, rr_ptr=WB_EX, src_full_o=0,
//    rf_we_o=0, rf_waddr_o=0, rf_data_o=0, rf_instr_id_o=0. A reset mid-operation discards every
//    queued entry; no RF write happens in the cycle after reset.
//  - Enqueue: at posedge, src_we_i[s]=1 with src_waddr_i[s]!=0 pushes {waddr,data,id} into FIFO s.
//    Writes to x0 are dropped silently and do not count as an enqueue.
//  - src_full_o[s] = (count[s]==FIFO_DEPTH), driven from registered count.
//  - Enqueue while full is accepted only if FIFO s is granted that same cycle; otherwise the write
//    is lost and a protocol assertion fires.
//  - Arbitration (comb, each cycle): among non-empty FIFOs, the first at or after rr_ptr in the
//    order EX->MEM->RVM->EX is granted. The head of the granted FIFO is popped at posedge and
//    registered onto rf_*_o; rf_we_o=1 for exactly that one cycle.
//    rr_ptr <= grant+1 (mod 3) on a grant; unchanged when all FIFOs are empty.
//  - No grant: rf_we_o=0; rf_waddr/data/id hold their last value.
//  - Latency: input sampled at edge N, head visible in N+1, RF write visible after edge N+1
//    (2 cycles minimum).
//  - Enqueue and pop on the same FIFO in one cycle: count unchanged, pointers both advance and
//    wrap modulo FIFO_DEPTH.
//  - Ordering: FIFO order within a source is preserved. Upstream guarantees that no two in-flight
//    writes from different sources target the same waddr; an assertion checks this across the
//    FIFO contents.
// CONFIGURATION
//  SEGRE_WB_ARB_PERF_EN defined: adds outputs perf_full_cnt_o (3 x 32) and perf_conflict_cnt_o
//  (32), all saturating.
//   - perf_full_cnt_o[s] increments each cycle src_full_o[s]=1.
//   - perf_conflict_cnt_o increments each cycle >=2 FIFOs are non-empty.
//   - Both reset to 0.
//  SEGRE_WB_ARB_PERF_EN undefined: these ports and counters do not exist; all other behaviour is
//  identical.
// STRUCTURE
//  segre_pkg additions:
//   - enum wb_src_e {WB_EX=0, WB_MEM=1, WB_RVM=2}
//   - localparam NUM_WB_SRC=3
//   - struct wb_entry_t {waddr, data, instr_id}
//  Sub-module segre_wb_fifo: one-write/one-read FIFO of wb_entry_t, parameter FIFO_DEPTH, outputs
//  head, empty, full; instantiated three times. Arbiter, rr_ptr and output registers live in top.
// TESTING
//  1 Reset: drive all src_we_i=1 during rsn_i=0 -> no rf_we_o after release; src_full_o=0.
//  2 Single EX write x5=0xDEAD_BEEF id=3 at edge N -> rf_we_o=1, waddr=5, data=0xDEADBEEF, id=3
//    after edge N+1, for one cycle only.
//  3 EX, MEM, RVM all write x1/x2/x3 in the same cycle, rr_ptr=EX -> RF writes x1, x2, x3 on three
//    consecutive cycles; rr_ptr ends at EX.
//  4 MEM writes x7 on 3 consecutive cycles, FIFO_DEPTH=2, with EX also writing each cycle
//    -> src_full_o[MEM]=1; all 3 MEM writes are retired in order; nothing is lost.
//  5 Write to x0 from RVM -> no enqueue, no rf_we_o, count stays 0.
//  6 Reset asserted with 2 entries queued -> queue is empty afterwards; no stale rf_we_o.
//    With SEGRE_WB_ARB_PERF_EN, also check the counters clear.

Source files
------------

// File: rtl/segre_wb_arbiter_pkg.sv
// Shared types and widths for the write-back arbiter.
package segre_wb_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_SIZE   = 5;
  localparam int unsigned HF_PTR     = 4;
  localparam int unsigned NUM_WB_SRC = 3;
  localparam int unsigned PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    WB_EX  = 2'd0,
    WB_MEM = 2'd1,
    WB_RVM = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [REG_SIZE-1:0]   waddr;
    logic [DATA_WIDTH-1:0] data;
    logic [HF_PTR-1:0]     instr_id;
  } wb_entry_t;

  // Round-robin successor in the order EX -> MEM -> RVM -> EX.
  function automatic wb_src_e wb_src_next(input wb_src_e s);
    case (s)
      WB_EX:   return WB_MEM;
      WB_MEM:  return WB_RVM;
      default: return WB_EX;
    endcase
  endfunction

endpackage

// File: rtl/segre_wb_arbiter_if.sv
// Completion-side and register-file-side signals of the write-back arbiter.
// Perf counter signals exist only when SEGRE_WB_ARB_PERF_EN is defined.
interface segre_wb_arbiter_if;
  import segre_wb_arbiter_pkg::*;

  logic [NUM_WB_SRC-1:0]                 src_we_i;
  logic [NUM_WB_SRC-1:0][REG_SIZE-1:0]   src_waddr_i;
  logic [NUM_WB_SRC-1:0][DATA_WIDTH-1:0] src_data_i;
  logic [NUM_WB_SRC-1:0][HF_PTR-1:0]     src_id_i;
  logic [NUM_WB_SRC-1:0]                 src_full_o;
  logic                                  rf_we_o;
  logic [REG_SIZE-1:0]                   rf_waddr_o;
  logic [DATA_WIDTH-1:0]                 rf_data_o;
  logic [HF_PTR-1:0]                     rf_instr_id_o;
`ifdef SEGRE_WB_ARB_PERF_EN
  logic [NUM_WB_SRC-1:0][PERF_CNT_W-1:0] perf_full_cnt_o;
  logic [PERF_CNT_W-1:0]                 perf_conflict_cnt_o;
`endif

  modport master (
    output src_we_i, src_waddr_i, src_data_i, src_id_i,
    input  src_full_o, rf_we_o, rf_waddr_o, rf_data_o, rf_instr_id_o
`ifdef SEGRE_WB_ARB_PERF_EN
    , input perf_full_cnt_o, perf_conflict_cnt_o
`endif
  );

  modport slave (
    input  src_we_i, src_waddr_i, src_data_i, src_id_i,
    output src_full_o, rf_we_o, rf_waddr_o, rf_data_o, rf_instr_id_o
`ifdef SEGRE_WB_ARB_PERF_EN
    , output perf_full_cnt_o, perf_conflict_cnt_o
`endif
  );

endinterface

// File: rtl/segre_wb_arbiter_fifo.sv
// Per-source skid FIFO of write-back entries; a push into a full FIFO is taken
// only when the head is popped in the same cycle.
module segre_wb_fifo
  import segre_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rsn_i,
  input  logic                        push_i,
  input  wb_entry_t                   entry_i,
  input  logic                        pop_i,
  output wb_entry_t                   head_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [FIFO_DEPTH-1:0]       vld_o,
  output wb_entry_t [FIFO_DEPTH-1:0]  mem_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  wb_entry_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [FIFO_DEPTH-1:0]      vld_q, vld_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic                       wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = ~|vld_q;
  assign full_o  = &vld_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign vld_o   = vld_q;
  assign mem_o   = mem_q;

  // Slot freed by the pop is cleared before the push may refill it.
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_en    = pop_i && !empty_o;
    wr_en    = push_i && (!full_o || rd_en);
    if (rd_en) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (wr_en) begin
      mem_d[wr_ptr_q] = entry_i;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/segre_wb_arbiter.sv
// Round-robin arbiter sharing the RF write port between EX, MEM and RVM completions.
// SEGRE_WB_ARB_PERF_EN adds saturating full / conflict occupancy counters.
module segre_wb_arbiter
  import segre_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  segre_wb_arbiter_if.slave wb
);

  wb_entry_t [NUM_WB_SRC-1:0]                 src_entry;
  wb_entry_t [NUM_WB_SRC-1:0]                 fifo_head;
  wb_entry_t [NUM_WB_SRC-1:0][FIFO_DEPTH-1:0] fifo_mem;
  logic [NUM_WB_SRC-1:0][FIFO_DEPTH-1:0]      fifo_vld;
  logic [NUM_WB_SRC-1:0]                      push, pop, fifo_empty, fifo_full;

  wb_src_e   rr_q, rr_d, gnt_src, cand;
  logic      gnt_vld;
  logic      rf_we_q, rf_we_d;
  wb_entry_t rf_entry_q, rf_entry_d;
  logic      waddr_conflict;

  for (genvar s = 0; s < NUM_WB_SRC; s++) begin : g_src
    // Writes to x0 never enter the queue.
    assign push[s]      = wb.src_we_i[s] && (wb.src_waddr_i[s] != '0);
    assign src_entry[s] = '{waddr: wb.src_waddr_i[s], data: wb.src_data_i[s],
                            instr_id: wb.src_id_i[s]};

    segre_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rsn_i   (rsn_i),
      .push_i  (push[s]),
      .entry_i (src_entry[s]),
      .pop_i   (pop[s]),
      .head_o  (fifo_head[s]),
      .empty_o (fifo_empty[s]),
      .full_o  (fifo_full[s]),
      .vld_o   (fifo_vld[s]),
      .mem_o   (fifo_mem[s])
    );
  end

  // First non-empty source at or after rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = rr_q;
    cand    = rr_q;
    for (int k = 0; k < NUM_WB_SRC; k++) begin
      if (!gnt_vld && !fifo_empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_src = cand;
      end
      cand = wb_src_next(cand);
    end
    pop = gnt_vld ? (NUM_WB_SRC'(1) << gnt_src) : '0;
  end

  always_comb begin
    rf_we_d    = gnt_vld;
    rf_entry_d = rf_entry_q;
    rr_d       = rr_q;
    if (gnt_vld) begin
      rf_entry_d = fifo_head[gnt_src];
      rr_d       = wb_src_next(gnt_src);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      rf_we_q    <= 1'b0;
      rf_entry_q <= '0;
      rr_q       <= WB_EX;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_entry_q <= rf_entry_d;
      rr_q       <= rr_d;
    end
  end

  assign wb.src_full_o    = fifo_full;
  assign wb.rf_we_o       = rf_we_q;
  assign wb.rf_waddr_o    = rf_entry_q.waddr;
  assign wb.rf_data_o     = rf_entry_q.data;
  assign wb.rf_instr_id_o = rf_entry_q.instr_id;

`ifdef SEGRE_WB_ARB_PERF_EN
  logic [NUM_WB_SRC-1:0][PERF_CNT_W-1:0] perf_full_cnt_q, perf_full_cnt_d;
  logic [PERF_CNT_W-1:0]                 perf_conflict_cnt_q, perf_conflict_cnt_d;
  logic                                  multi_pending;

  assign multi_pending = (!fifo_empty[0] && !fifo_empty[1]) ||
                         (!fifo_empty[0] && !fifo_empty[2]) ||
                         (!fifo_empty[1] && !fifo_empty[2]);

  always_comb begin
    perf_full_cnt_d     = perf_full_cnt_q;
    perf_conflict_cnt_d = perf_conflict_cnt_q;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      if (fifo_full[s] && (perf_full_cnt_q[s] != '1))
        perf_full_cnt_d[s] = perf_full_cnt_q[s] + PERF_CNT_W'(1);
    end
    if (multi_pending && (perf_conflict_cnt_q != '1))
      perf_conflict_cnt_d = perf_conflict_cnt_q + PERF_CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      perf_full_cnt_q     <= '0;
      perf_conflict_cnt_q <= '0;
    end else begin
      perf_full_cnt_q     <= perf_full_cnt_d;
      perf_conflict_cnt_q <= perf_conflict_cnt_d;
    end
  end

  assign wb.perf_full_cnt_o     = perf_full_cnt_q;
  assign wb.perf_conflict_cnt_o = perf_conflict_cnt_q;
`endif

  // Any two queued entries of different sources sharing a destination register.
  always_comb begin
    waddr_conflict = 1'b0;
    for (int a = 0; a < NUM_WB_SRC; a++)
      for (int b = a + 1; b < NUM_WB_SRC; b++)
        for (int i = 0; i < FIFO_DEPTH; i++)
          for (int j = 0; j < FIFO_DEPTH; j++)
            if (fifo_vld[a][i] && fifo_vld[b][j] &&
                (fifo_mem[a][i].waddr == fifo_mem[b][j].waddr))
              waddr_conflict = 1'b1;
  end

  always @(posedge clk_i) begin
    if (rsn_i) begin
      for (int s = 0; s < NUM_WB_SRC; s++)
        assert (!(push[s] && fifo_full[s] && !pop[s]))
          else $error("segre_wb_arbiter: write from source %0d lost, FIFO full", s);
      assert (!waddr_conflict)
        else $error("segre_wb_arbiter: in-flight waddr shared across sources");
    end
  end

endmodule

// File: tb/tb_segre_wb_arbiter.sv
// Directed bench for segre_wb_arbiter: vector table plus multi-cycle sequences.
// Also checks the counters when SEGRE_WB_ARB_PERF_EN is defined.
module tb_segre_wb_arbiter;
  import segre_wb_arbiter_pkg::*;

  logic clk;
  logic rsn;
  int   n_tests = 0;
  int   n_fail  = 0;

  segre_wb_arbiter_if wb_if();

  segre_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .wb    (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       we;
    logic [2:0][4:0]  waddr;
    logic [2:0][31:0] data;
    logic [2:0][3:0]  id;
    logic             exp_we;
    logic [4:0]       exp_waddr;
    logic [31:0]      exp_data;
    logic [3:0]       exp_id;
    logic [2:0]       exp_full;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] we,
                              input logic [4:0] a0, input logic [31:0] d0, input logic [3:0] i0,
                              input logic [4:0] a1, input logic [31:0] d1, input logic [3:0] i1,
                              input logic [4:0] a2, input logic [31:0] d2, input logic [3:0] i2,
                              input logic ewe, input logic [4:0] ewa, input logic [31:0] ed,
                              input logic [3:0] eid);
    vec_t v;
    v.we        = we;
    v.waddr     = {a2, a1, a0};
    v.data      = {d2, d1, d0};
    v.id        = {i2, i1, i0};
    v.exp_we    = ewe;
    v.exp_waddr = ewa;
    v.exp_data  = ed;
    v.exp_id    = eid;
    v.exp_full  = 3'b000;
    return v;
  endfunction

  task automatic idle_inputs();
    wb_if.src_we_i    = '0;
    wb_if.src_waddr_i = '0;
    wb_if.src_data_i  = '0;
    wb_if.src_id_i    = '0;
  endtask

  task automatic drive_src(input int s, input logic [4:0] a, input logic [31:0] d, input logic [3:0] id);
    wb_if.src_we_i[s]    = 1'b1;
    wb_if.src_waddr_i[s] = a;
    wb_if.src_data_i[s]  = d;
    wb_if.src_id_i[s]    = id;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  wb_entry_t got[$];
  wb_entry_t exp_seq[6];

  initial begin
    // All-source traffic (rr starts at EX), single EX write, x0 drop, rr order after MEM.
    vecs[0]  = mk(3'b111, 5'd1, 32'h1111_1111, 4'd1, 5'd2, 32'h2222_2222, 4'd2,
                  5'd3, 32'h3333_3333, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0);
    vecs[1]  = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b1, 5'd1, 32'h1111_1111, 4'd1);
    vecs[2]  = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b1, 5'd2, 32'h2222_2222, 4'd2);
    vecs[3]  = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b1, 5'd3, 32'h3333_3333, 4'd3);
    vecs[4]  = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b0, 5'd3, 32'h3333_3333, 4'd3);
    vecs[5]  = mk(3'b001, 5'd5, 32'hDEAD_BEEF, 4'd3, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b0, 5'd3, 32'h3333_3333, 4'd3);
    vecs[6]  = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b1, 5'd5, 32'hDEAD_BEEF, 4'd3);
    vecs[7]  = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b0, 5'd5, 32'hDEAD_BEEF, 4'd3);
    vecs[8]  = mk(3'b100, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h5555_5555, 4'd7,
                  1'b0, 5'd5, 32'hDEAD_BEEF, 4'd3);
    vecs[9]  = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b0, 5'd5, 32'hDEAD_BEEF, 4'd3);
    vecs[10] = mk(3'b101, 5'd8, 32'h8888_8888, 4'd4, 5'd0, 32'h0, 4'd0, 5'd9, 32'h9999_9999, 4'd5,
                  1'b0, 5'd5, 32'hDEAD_BEEF, 4'd3);
    vecs[11] = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b1, 5'd9, 32'h9999_9999, 4'd5);
    vecs[12] = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b1, 5'd8, 32'h8888_8888, 4'd4);
    vecs[13] = mk(3'b000, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0, 5'd0, 32'h0, 4'd0,
                  1'b0, 5'd8, 32'h8888_8888, 4'd4);

    // Reset with all sources writing: nothing may be queued or retired.
    rsn = 1'b0;
    idle_inputs();
    drive_src(0, 5'd1, 32'hA, 4'd1);
    drive_src(1, 5'd2, 32'hB, 4'd2);
    drive_src(2, 5'd3, 32'hC, 4'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_we", 64'(wb_if.rf_we_o), 64'd0);
      check("rst_hold_full", 64'(wb_if.src_full_o), 64'd0);
    end
    rsn = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_rel_we", 64'(wb_if.rf_we_o), 64'd0);
      check("rst_rel_full", 64'(wb_if.src_full_o), 64'd0);
    end
    check("rst_waddr", 64'(wb_if.rf_waddr_o), 64'd0);
    check("rst_data", 64'(wb_if.rf_data_o), 64'd0);
    check("rst_id", 64'(wb_if.rf_instr_id_o), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      wb_if.src_we_i    = vecs[i].we;
      wb_if.src_waddr_i = vecs[i].waddr;
      wb_if.src_data_i  = vecs[i].data;
      wb_if.src_id_i    = vecs[i].id;
      step();
      idle_inputs();
      check($sformatf("vec%0d_we", i), 64'(wb_if.rf_we_o), 64'(vecs[i].exp_we));
      check($sformatf("vec%0d_waddr", i), 64'(wb_if.rf_waddr_o), 64'(vecs[i].exp_waddr));
      check($sformatf("vec%0d_data", i), 64'(wb_if.rf_data_o), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_id", i), 64'(wb_if.rf_instr_id_o), 64'(vecs[i].exp_id));
      check($sformatf("vec%0d_full", i), 64'(wb_if.src_full_o), 64'(vecs[i].exp_full));
    end

    // MEM x7 three cycles running alongside EX (rr at MEM): MEM fills, nothing lost.
    exp_seq[0] = '{waddr: 5'd7,  data: 32'h70A, instr_id: 4'd1};
    exp_seq[1] = '{waddr: 5'd10, data: 32'hA0,  instr_id: 4'd4};
    exp_seq[2] = '{waddr: 5'd7,  data: 32'h70B, instr_id: 4'd2};
    exp_seq[3] = '{waddr: 5'd11, data: 32'hA1,  instr_id: 4'd5};
    exp_seq[4] = '{waddr: 5'd7,  data: 32'h70C, instr_id: 4'd3};
    exp_seq[5] = '{waddr: 5'd12, data: 32'hA2,  instr_id: 4'd6};
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c < 3) begin
        drive_src(0, 5'(10 + c), 32'(32'hA0 + c), 4'(4 + c));
        drive_src(1, 5'd7, 32'(32'h70A + c), 4'(1 + c));
      end
      step();
      if (c == 2) check("burst_full_mem", 64'(wb_if.src_full_o[1]), 64'd1);
      if (wb_if.rf_we_o)
        got.push_back('{waddr: wb_if.rf_waddr_o, data: wb_if.rf_data_o,
                        instr_id: wb_if.rf_instr_id_o});
    end
    idle_inputs();
    check("burst_count", 64'(got.size()), 64'd6);
    if (got.size() == 6)
      for (int k = 0; k < 6; k++)
        check($sformatf("burst_retire%0d", k), 64'(got[k]), 64'(exp_seq[k]));
    check("burst_full_end", 64'(wb_if.src_full_o), 64'd0);

    // Reset with two entries queued.
    drive_src(0, 5'd4, 32'h44, 4'd2);
    drive_src(1, 5'd5, 32'h55, 4'd3);
    step();
    idle_inputs();
    check("q2_pre_we", 64'(wb_if.rf_we_o), 64'd0);
    rsn = 1'b0;
    step();
    rsn = 1'b1;
    check("q2_rst_waddr", 64'(wb_if.rf_waddr_o), 64'd0);
    check("q2_rst_data", 64'(wb_if.rf_data_o), 64'd0);
    check("q2_rst_full", 64'(wb_if.src_full_o), 64'd0);
`ifdef SEGRE_WB_ARB_PERF_EN
    check("perf_full_clr", 64'(wb_if.perf_full_cnt_o), 64'd0);
    check("perf_conf_clr", 64'(wb_if.perf_conflict_cnt_o), 64'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      check("q2_post_we", 64'(wb_if.rf_we_o), 64'd0);
    end

    // Path still works after the mid-run reset.
    drive_src(2, 5'd6, 32'h66, 4'd9);
    step();
    idle_inputs();
    check("post_rst_lat1_we", 64'(wb_if.rf_we_o), 64'd0);
    step();
    check("post_rst_we", 64'(wb_if.rf_we_o), 64'd1);
    check("post_rst_waddr", 64'(wb_if.rf_waddr_o), 64'd6);
    check("post_rst_data", 64'(wb_if.rf_data_o), 64'h66);
    check("post_rst_id", 64'(wb_if.rf_instr_id_o), 64'd9);
    step();
    check("post_rst_we_drop", 64'(wb_if.rf_we_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
